mux_4x1_rr: RTL and testbench
=============================

Name: mux_4x1_rr

Overview:
- Four-input round-robin collecting multiplexer; the inverse of the 1-to-4 demux path.
- Merges four valid/ready input channels onto one registered output channel.
- Emits the source channel's select bits (s0, s1) alongside each word, so a downstream demux_1x4 with the same s0/s1 convention routes each word back to its originating lane.
- Sits in front of a shared serial/bus resource; one word per clock maximum throughput.

Parameters:
WIDTH, 8, data width of every input channel and the output.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
d0  input  WIDTH  channel 0 data
d1  input  WIDTH  channel 1 data
d2  input  WIDTH  channel 2 data
d3  input  WIDTH  channel 3 data
v0..v3  input  1 each  channel n valid
r0..r3  output  1 each  channel n ready (handshake fires when vn & rn at clk edge)
y  output  WIDTH  registered output data
yv  output  1  output valid
yr  input  1  downstream ready
s0  output  1  source channel index bit 1 (upper/lower pair, as demux_1x4 s0)
s1  output  1  source channel index bit 0 (within pair, as demux_1x4 s1)

Behaviour:
- Channel index n = {s0,s1}: ch0=00, ch1=01, ch2=10, ch3=11.
- Reset (async, rst=1): y=0, yv=0, s0=0, s1=0, round-robin pointer ptr=0. All rn=0 while rst=1.
- Load enable: le = ~yv | yr (output register empty or being drained this cycle).
- Arbitration (combinational):
  - Scan channels ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Grant g is the first channel with vn=1.
  - rn = le & (n==g) & any valid. At most one rn high per cycle.
  - rn may depend combinationally on yr and vn; no rn depends on its own vn loop beyond this.
- On clk edge with le=1:
  - If some vn=1: y<=d[g], {s0,s1}<=g, yv<=1, ptr<=(g+1) mod 4 (wraps 3->0).
  - If no vn=1: yv<=0. y, s0, s1 and ptr are held.
- On clk edge with le=0 (yv=1, yr=0): y, s0, s1, yv and ptr are all held stable. No input is accepted.
- Latency: an input accepted at edge k appears on y/yv at edge k (registered). It is visible from the cycle after the handshake.
- Throughput: with yr held 1, one word per cycle.
- Fairness: a continuously asserting channel waits at most 3 grants for its turn.
- Source order is preserved per channel. Words from the same channel leave in arrival order.
- Simultaneous drain and load (yv=1, yr=1, some vn=1): new word replaces old in the same edge, with no bubble.
- Input data need not be held after its handshake. Inputs are not sampled when rn=0.
- Reset mid-operation: the pending output word is discarded, yv=0 immediately (async), and ptr returns to 0.
- Undriven or X on vn when rst=0 is a bench error, not handled.

Test Plan:
1. Reset check: rst=1 with all vn=1 -> y=0, yv=0, s0=s1=0, r0..r3=0. Release rst with yr=1 and only v0=1, d0=8'hA5 -> after one edge y=A5, yv=1, s0=0, s1=0.
2. Round-robin rotation: v0..v3 all 1 with d0=10, d1=11, d2=12, d3=13, yr=1, 8 cycles -> y sequence 10,11,12,13,10,11,12,13; {s0,s1} sequence 00,01,10,11 repeating; r0..r3 each high on exactly one cycle in four.
3. Backpressure: stream ch2 (d2=8'h3C), then drop yr=0 for 3 cycles -> y=3C, s0=1, s1=0, yv=1 held constant; r0..r3=0 throughout. Raise yr -> next word loads on the same edge, with no gap.
4. Skip and wrap: after a grant to ch3 (ptr=0), only v1=1 and v2=1 -> grant ch1 first ({s0,s1}=01), then ch2 (10). The pointer then advances to 3.
5. Idle drain: single word from ch1, then all vn=0 with yr=1 -> yv=1 for one cycle, then yv=0 with y and s0/s1 held at their last values.
6. Async reset mid-stream: assert rst between clock edges while yv=1, y=8'h77 -> yv=0 and y=0 immediately, before the next edge. After release with all vn=1, ch0 is granted first.

Source files
------------

// File: rtl/mux_4x1_rr.sv
// Four-input round-robin collecting multiplexer: merges four valid/ready lanes onto one
// registered output and tags each word with its source lane as {s0,s1}.
module mux_4x1_rr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             v0,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    output logic             r0,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic [WIDTH-1:0] y,
    output logic             yv,
    input  logic             yr,
    output logic             s0,
    output logic             s1
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0][WIDTH-1:0] din;
    logic [NUM_LANES-1:0]            vin;
    logic [NUM_LANES-1:0]            rdy;
    logic [1:0]                      ptr;
    logic [1:0]                      g;
    logic [1:0]                      sel;
    logic                            any_v;
    logic                            le;

    assign din = {d3, d2, d1, d0};
    assign vin = {v3, v2, v1, v0};

    // Output register accepts a word when empty or being drained; held off during reset.
    assign le = ~rst & (~yv | yr);

    // Scan from ptr upward; iterating highest offset first leaves the nearest valid lane in g.
    always_comb begin
        g     = ptr;
        any_v = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (vin[ptr + 2'(i)]) begin
                g     = ptr + 2'(i);
                any_v = 1'b1;
            end
        end
    end

    always_comb begin
        rdy = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            rdy[n] = le & any_v & (g == 2'(n));
        end
    end

    assign {r3, r2, r1, r0} = rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y   <= '0;
            yv  <= 1'b0;
            sel <= 2'b00;
            ptr <= 2'b00;
        end else if (le) begin
            if (any_v) begin
                y   <= din[g];
                sel <= g;
                yv  <= 1'b1;
                ptr <= g + 2'd1;
            end else begin
                yv  <= 1'b0;
            end
        end
    end

    assign s0 = sel[1];
    assign s1 = sel[0];

endmodule

// File: tb/tb_mux_4x1_rr.sv
// Bench for mux_4x1_rr: table of per-cycle vectors with hand-derived grants/outputs,
// a payload scoreboard, and a hand-written async-reset sequence.
module tb_mux_4x1_rr;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] v;
    logic [3:0][7:0] d;
    logic       yr;
    logic       r0, r1, r2, r3;
    logic [7:0] y;
    logic       yv, s0, s1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]      v;
        logic            yr;
        logic [3:0][7:0] d;
        logic [3:0]      er;
        logic [7:0]      ey;
        logic            eyv;
        logic [1:0]      es;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        logic [1:0] s;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    mux_4x1_rr #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .v0(v[0]), .v1(v[1]), .v2(v[2]), .v3(v[3]),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .y(y), .yv(yv), .yr(yr), .s0(s0), .s1(s1)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] vv, input logic yy, input logic [31:0] dd,
                                input logic [3:0] er, input logic [7:0] ey, input logic eyv,
                                input logic [1:0] es);
        vec_t t;
        t.v = vv; t.yr = yy; t.d = dd; t.er = er; t.ey = ey; t.eyv = eyv; t.es = es;
        return t;
    endfunction

    // Drive one cycle's inputs, check grants before the edge, outputs after it.
    task automatic apply(input vec_t t, input int idx);
        logic [3:0] rv;
        bit pushed;
        exp_t e;
        pushed = 0;
        v = t.v; yr = t.yr; d = t.d;
        #1;
        rv = {r3, r2, r1, r0};
        chk($sformatf("ready[%0d]", idx), 32'(rv), 32'(t.er));
        for (int n = 0; n < 4; n++) begin
            if (rv[n] && v[n]) begin
                e.y = d[n]; e.s = 2'(n);
                sb.push_back(e);
                pushed = 1;
            end
        end
        @(posedge clk);
        #1;
        chk($sformatf("y[%0d]", idx), 32'(y), 32'(t.ey));
        chk($sformatf("yv[%0d]", idx), 32'(yv), 32'(t.eyv));
        chk($sformatf("sel[%0d]", idx), 32'({s0, s1}), 32'(t.es));
        if (pushed) begin
            if (sb.size() == 0) begin
                chk($sformatf("sb_empty[%0d]", idx), 32'(0), 32'(1));
            end else begin
                e = sb.pop_front();
                chk($sformatf("sb_word[%0d]", idx), 32'({yv, s0, s1, y}), 32'({1'b1, e.s, e.y}));
            end
        end
    endtask

    localparam logic [31:0] D = 32'h13121110;

    initial begin
        // Test 1 and skip-and-wrap follow each other so the pointer path is fully hand-traced.
        tbl.push_back(mk(4'b0001, 1, 32'h131211A5, 4'b0001, 8'hA5, 1, 2'd0));
        tbl.push_back(mk(4'b1000, 1, D, 4'b1000, 8'h13, 1, 2'd3));
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(mk(4'b1111, 1, D, 4'b0001, 8'h10, 1, 2'd0));
            tbl.push_back(mk(4'b1111, 1, D, 4'b0010, 8'h11, 1, 2'd1));
            tbl.push_back(mk(4'b1111, 1, D, 4'b0100, 8'h12, 1, 2'd2));
            tbl.push_back(mk(4'b1111, 1, D, 4'b1000, 8'h13, 1, 2'd3));
        end
        tbl.push_back(mk(4'b0110, 1, D, 4'b0010, 8'h11, 1, 2'd1));
        tbl.push_back(mk(4'b0110, 1, D, 4'b0100, 8'h12, 1, 2'd2));
        tbl.push_back(mk(4'b1111, 1, D, 4'b1000, 8'h13, 1, 2'd3));
        tbl.push_back(mk(4'b0100, 1, 32'h133C1110, 4'b0100, 8'h3C, 1, 2'd2));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(4'b0100, 0, 32'h133C1110, 4'b0000, 8'h3C, 1, 2'd2));
        tbl.push_back(mk(4'b0100, 1, 32'h133D1110, 4'b0100, 8'h3D, 1, 2'd2));
        tbl.push_back(mk(4'b0010, 1, D, 4'b0010, 8'h11, 1, 2'd1));
        tbl.push_back(mk(4'b0000, 1, D, 4'b0000, 8'h11, 0, 2'd1));
        tbl.push_back(mk(4'b0000, 1, D, 4'b0000, 8'h11, 0, 2'd1));
        tbl.push_back(mk(4'b0001, 0, D, 4'b0001, 8'h10, 1, 2'd0));
        tbl.push_back(mk(4'b0000, 0, D, 4'b0000, 8'h10, 1, 2'd0));
        tbl.push_back(mk(4'b0000, 1, D, 4'b0000, 8'h10, 0, 2'd0));
        tbl.push_back(mk(4'b0001, 1, 32'h13121177, 4'b0001, 8'h77, 1, 2'd0));

        // Reset with every lane requesting: nothing may be granted.
        rst = 1; v = 4'b1111; yr = 1; d = D;
        #2;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_yv", 32'(yv), 32'h0);
        chk("rst_sel", 32'({s0, s1}), 32'h0);
        chk("rst_ready", 32'({r3, r2, r1, r0}), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_yv", 32'(yv), 32'h0);
        chk("rst_hold_ready", 32'({r3, r2, r1, r0}), 32'h0);
        rst = 0;

        foreach (tbl[i]) apply(tbl[i], i);

        // Async reset between edges while y=77 is pending; pointer sits at 1 beforehand.
        v = 4'b0000; yr = 0;
        #2;
        rst = 1; v = 4'b1111;
        #1;
        chk("async_yv", 32'(yv), 32'h0);
        chk("async_y", 32'(y), 32'h0);
        chk("async_ready", 32'({r3, r2, r1, r0}), 32'h0);
        @(negedge clk);
        rst = 0; yr = 1; d = D;
        #1;
        chk("post_rst_ready", 32'({r3, r2, r1, r0}), 32'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_word", 32'({yv, s0, s1, y}), 32'({1'b1, 2'b00, 8'h10}));

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
